// File: rtl/mdio_mgmt_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mdio_mgmt_ctrl                                             |
// | Description : Clause-22 MII management master. Accepts one read/write    |
// |               command at a time, generates MDC, serialises the frame on  |
// |               mdo/mdoEn, samples mdi and returns read data together with |
// |               a no-PHY error flag on a one-cycle response pulse.         |
// | Options     : MDIO_NOPRE_EN adds input cmd_nopre (preamble suppression). |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mdio_mgmt_ctrl #(
  parameter int CLK_DIV = 20,  // MDC half-period in clock cycles
  parameter int PRE_LEN = 32   // preamble length in bits
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
`ifdef MDIO_NOPRE_EN
  input  logic        cmd_nopre,
`endif
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdo,
  output logic        mdoEn,
  input  logic        mdi
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0]       PRE_LAST = 6'(PRE_LEN - 1);

  generate
    if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("mdio_mgmt_ctrl: CLK_DIV must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_TA   = 3'd3,
    S_DATA = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic [31:0]      frame_sr;    // ST..DATA, MSB is the bit currently on mdo
  logic             wr_q;
  logic             ta_sample;
  logic [15:0]      rdata_sr;
  logic             nopre_sel;
  logic             accept;
  logic             in_frame;
  logic             tick;
  logic             mdc_fall;
  logic             mdc_rise;
  logic             bit_last;

`ifdef MDIO_NOPRE_EN
  assign nopre_sel = cmd_nopre;
`else
  assign nopre_sel = 1'b0;
`endif

  assign accept   = cmd_valid && (state == S_IDLE);
  assign in_frame = (state == S_PRE) || (state == S_HDR) || (state == S_TA) || (state == S_DATA);
  assign tick     = in_frame && (div_cnt == DIV_LAST);
  assign mdc_fall = tick && mdc;
  assign mdc_rise = tick && !mdc;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state decode (advances on the MDC falling edge) and status outputs
  always_comb begin
    next_state = state;
    bit_last   = 1'b0;
    cmd_ready  = (state == S_IDLE);
    rsp_valid  = (state == S_DONE);
    busy       = (state != S_IDLE) || cmd_valid;
    case (state)
      S_PRE:  bit_last = (bit_cnt == PRE_LAST);
      S_HDR:  bit_last = (bit_cnt == 6'd13);
      S_TA:   bit_last = (bit_cnt == 6'd1);
      S_DATA: bit_last = (bit_cnt == 6'd15);
      default: bit_last = 1'b0;
    endcase
    case (state)
      S_IDLE: if (accept) next_state = nopre_sel ? S_HDR : S_PRE;
      S_PRE:  if (mdc_fall && bit_last) next_state = S_HDR;
      S_HDR:  if (mdc_fall && bit_last) next_state = S_TA;
      S_TA:   if (mdc_fall && bit_last) next_state = S_DATA;
      S_DATA: if (mdc_fall && bit_last) next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // MDC divider: held low/cleared outside a frame, toggles at terminal count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      mdc     <= 1'b0;
    end else if (accept || !in_frame) begin
      div_cnt <= '0;
      mdc     <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      mdc     <= ~mdc;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Serialiser: load frame on accept, present the next bit on each MDC fall
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      frame_sr <= '0;
      wr_q     <= 1'b0;
      mdo      <= 1'b1;
      mdoEn    <= 1'b0;
    end else if (accept) begin
      bit_cnt  <= '0;
      wr_q     <= cmd_write;
      // Read frames fill TA/DATA with ones; those bits are never driven.
      frame_sr <= {2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phy, cmd_reg,
                   (cmd_write ? 2'b10 : 2'b11), (cmd_write ? cmd_wdata : 16'hFFFF)};
      mdo      <= ~nopre_sel;   // first preamble one, or ST bit 0 when skipped
      mdoEn    <= 1'b1;
    end else if (mdc_fall) begin
      bit_cnt <= bit_last ? 6'd0 : bit_cnt + 6'd1;
      case (state)
        S_PRE: mdo <= bit_last ? frame_sr[31] : 1'b1;
        S_HDR, S_TA: begin
          frame_sr <= {frame_sr[30:0], 1'b1};
          mdo      <= frame_sr[30];
          // Reads release the line for the whole turnaround.
          if (state == S_HDR && bit_last) mdoEn <= wr_q;
        end
        S_DATA: begin
          frame_sr <= {frame_sr[30:0], 1'b1};
          if (bit_last) begin
            mdo   <= 1'b1;
            mdoEn <= 1'b0;
          end else begin
            mdo <= frame_sr[30];
          end
        end
        default: mdo <= 1'b1;
      endcase
    end
  end

  // Input sampler: mdi captured on the MDC rising edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ta_sample <= 1'b0;
      rdata_sr  <= '0;
    end else if (mdc_rise) begin
      if (state == S_TA && bit_cnt == 6'd1) ta_sample <= mdi;
      if (state == S_DATA) rdata_sr <= {rdata_sr[14:0], mdi};
    end
  end

  // Response registers: loaded on the edge that enters DONE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (state == S_DATA && next_state == S_DONE) begin
      rsp_rdata <= wr_q ? 16'h0000 : rdata_sr;
      rsp_err   <= wr_q ? 1'b0 : ta_sample;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdio_mgmt_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mdio_mgmt_ctrl                                          |
// | Description : Self-checking bench for mdio_mgmt_ctrl with a PHY model    |
// |               on mdo/mdoEn/mdi. Define MDIO_NOPRE_EN for the no-preamble |
// |               option.                                                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mdio_mgmt_ctrl;
  localparam int CLK_DIV = 4;
  localparam int PRE_LEN = 32;
  localparam int BIT_CYC = 2 * CLK_DIV;
  localparam int PERIOD  = 10;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_write;
  logic [4:0]  cmd_phy, cmd_reg;
  logic [15:0] cmd_wdata;
`ifdef MDIO_NOPRE_EN
  logic        cmd_nopre;
`endif
  logic        cmd_ready, rsp_valid, rsp_err, busy, mdc, mdo, mdoEn, mdi;
  logic [15:0] rsp_rdata;

  mdio_mgmt_ctrl #(.CLK_DIV(CLK_DIV), .PRE_LEN(PRE_LEN)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
`ifdef MDIO_NOPRE_EN
    .cmd_nopre(cmd_nopre),
`endif
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mdc(mdc), .mdo(mdo), .mdoEn(mdoEn), .mdi(mdi)
  );

  always #(PERIOD / 2) clock = ~clock;

  int  n_cmp = 0;
  int  n_bad = 0;
  time t_acc, t_rsp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected response from the command and the PHY behaviour
  function automatic logic [16:0] model_rsp(input logic wr, input logic present, input logic [15:0] pdata);
    if (wr)           return {1'b0, 16'h0000};
    else if (present) return {1'b0, pdata};
    else              return {1'b1, 16'hFFFF};
  endfunction

  // One complete frame with a PHY model; checks every cycle of the frame
  task automatic run_frame(input string tag, input logic wr, input logic [4:0] phy,
                           input logic [4:0] rg, input logic [15:0] wd, input logic present,
                           input logic [15:0] pdata, input logic [15:0] exp_rdata,
                           input logic exp_err, input logic nopre, input logic keep_valid);
    logic        ebit[$];
    logic        edrv[$];
    logic        emdi[$];
    logic [13:0] hdr;
    int nb, lat_exp, lat, b, w, mdo_err, en_err, mdc_err, hs_err, gap_err;
    hdr = {2'b01, (wr ? 2'b01 : 2'b10), phy, rg};
    if (!nopre)
      for (int i = 0; i < PRE_LEN; i++) begin ebit.push_back(1'b1); edrv.push_back(1'b1); emdi.push_back(1'b1); end
    for (int i = 13; i >= 0; i--) begin ebit.push_back(hdr[i]); edrv.push_back(1'b1); emdi.push_back(1'b1); end
    if (wr) begin
      ebit.push_back(1'b1); edrv.push_back(1'b1); emdi.push_back(1'b1);
      ebit.push_back(1'b0); edrv.push_back(1'b1); emdi.push_back(1'b1);
    end else begin
      ebit.push_back(1'b1); edrv.push_back(1'b0); emdi.push_back(1'b1);
      ebit.push_back(1'b1); edrv.push_back(1'b0); emdi.push_back(!present);
    end
    for (int i = 15; i >= 0; i--) begin
      ebit.push_back(wr ? wd[i] : 1'b1);
      edrv.push_back(wr);
      emdi.push_back(wr ? 1'b1 : (present ? pdata[i] : 1'b1));
    end
    nb      = ebit.size();
    lat_exp = nb * BIT_CYC;

    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = wr; cmd_phy = phy; cmd_reg = rg; cmd_wdata = wd;
`ifdef MDIO_NOPRE_EN
    cmd_nopre = nopre;
`endif
    w = 0; gap_err = 0;
    while (cmd_ready !== 1'b1 && w < 4000) begin
      if (mdc !== 1'b0) gap_err++;
      @(negedge clock);
      w++;
    end
    if (w >= 4000) begin
      check({tag, " accept timeout"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    if (keep_valid || w > 0) check({tag, " mdc low between frames"}, 32'(gap_err), 32'd0);
    @(posedge clock);
    t_acc = $time;
    #1;
    if (!keep_valid) cmd_valid = 1'b0;

    lat = -1; mdo_err = 0; en_err = 0; mdc_err = 0; hs_err = 0;
    for (int k = 0; k <= lat_exp + 16; k++) begin
      if (k > 0) begin @(posedge clock); #1; end
      b = k / BIT_CYC;
      mdi = (b < nb) ? emdi[b] : 1'b1;
      if (rsp_valid === 1'b1) begin lat = k; break; end
      if (busy !== 1'b1 || cmd_ready !== 1'b0) hs_err++;
      if (b < nb) begin
        if (mdc !== ((k % BIT_CYC) >= CLK_DIV)) mdc_err++;
        if (mdoEn !== edrv[b]) en_err++;
        if (edrv[b] && mdo !== ebit[b]) mdo_err++;
      end
    end
    t_rsp = $time - 1;
    check({tag, " latency"},   32'(lat), 32'(lat_exp));
    check({tag, " mdo bits"},  32'(mdo_err), 32'd0);
    check({tag, " mdoEn"},     32'(en_err), 32'd0);
    check({tag, " mdc shape"}, 32'(mdc_err), 32'd0);
    check({tag, " busy/ready"}, 32'(hs_err), 32'd0);
    check({tag, " rdata"},     32'(rsp_rdata), 32'(exp_rdata));
    check({tag, " err"},       32'(rsp_err), 32'(exp_err));
    check({tag, " done ready/mdoEn"}, {30'd0, cmd_ready, mdoEn}, 32'd0);
    if (!keep_valid) begin
      @(posedge clock); #1;
      check({tag, " pulse width"}, {15'd0, rsp_valid, rsp_rdata}, {16'd0, exp_rdata});
    end
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] wd;
    logic        present;
    logic [15:0] pdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [16:0] m;
    logic        r_wr, r_pr;
    logic [4:0]  r_phy, r_rg;
    logic [15:0] r_wd, r_pd;
    time         tr;
    int          seen;

    vecs[0] = '{wr: 1'b1, phy: 5'd1,  rg: 5'd0,  wd: 16'h1140, present: 1'b0, pdata: 16'h0000, exp_rdata: 16'h0000, exp_err: 1'b0};
    vecs[1] = '{wr: 1'b0, phy: 5'd3,  rg: 5'd2,  wd: 16'h0000, present: 1'b1, pdata: 16'h0141, exp_rdata: 16'h0141, exp_err: 1'b0};
    vecs[2] = '{wr: 1'b0, phy: 5'd7,  rg: 5'd1,  wd: 16'h0000, present: 1'b0, pdata: 16'h0000, exp_rdata: 16'hFFFF, exp_err: 1'b1};
    vecs[3] = '{wr: 1'b1, phy: 5'd31, rg: 5'd31, wd: 16'hFFFF, present: 1'b0, pdata: 16'h0000, exp_rdata: 16'h0000, exp_err: 1'b0};

    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_phy = '0; cmd_reg = '0; cmd_wdata = '0; mdi = 1'b1;
`ifdef MDIO_NOPRE_EN
    cmd_nopre = 1'b0;
`endif
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset mdc/mdo/mdoEn", {29'd0, mdc, mdo, mdoEn}, 32'b010);
    check("reset rsp", {15'd0, rsp_valid, rsp_err, rsp_rdata}, 32'd0);
    check("reset busy/ready", {30'd0, busy, cmd_ready}, 32'b01);
    @(negedge clock) reset = 1'b0;

    // Directed table
    for (int i = 0; i < 4; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].wr, vecs[i].phy, vecs[i].rg, vecs[i].wd,
                vecs[i].present, vecs[i].pdata, vecs[i].exp_rdata, vecs[i].exp_err, 1'b0, 1'b0);

    // Random commands against the response model
    for (int i = 0; i < 6; i++) begin
      r_wr  = 1'($urandom_range(0, 1));
      r_phy = 5'($urandom);
      r_rg  = 5'($urandom);
      r_wd  = 16'($urandom);
      r_pr  = ($urandom_range(0, 3) != 0);
      r_pd  = 16'($urandom);
      m     = model_rsp(r_wr, r_pr, r_pd);
      run_frame($sformatf("rnd%0d", i), r_wr, r_phy, r_rg, r_wd, r_pr, r_pd, m[15:0], m[16], 1'b0, 1'b0);
    end

    // Back-to-back writes with cmd_valid held
    run_frame("b2b_a", 1'b1, 5'd1, 5'd4, 16'hA5A5, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    tr = t_rsp;
    run_frame("b2b_b", 1'b1, 5'd1, 5'd4, 16'hA5A5, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    check("b2b accept gap cycles", 32'((t_acc - tr) / PERIOD), 32'd2);

    // Reset during read DATA bit 7
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_phy = 5'd3; cmd_reg = 5'd2;
    @(posedge clock); #1 cmd_valid = 1'b0;
    repeat ((PRE_LEN + 16 + 7) * BIT_CYC + CLK_DIV) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("abort mdc/mdoEn/mdo", {29'd0, mdc, mdoEn, mdo}, 32'b001);
    check("abort busy/ready/valid", {29'd0, busy, cmd_ready, rsp_valid}, 32'b010);
    @(negedge clock);
    @(negedge clock) reset = 1'b0;
    seen = 0;
    repeat (600) begin
      @(posedge clock); #1;
      if (rsp_valid === 1'b1) seen++;
    end
    check("abort no rsp_valid", 32'(seen), 32'd0);
    run_frame("post_reset", 1'b1, 5'd2, 5'd9, 16'h3C5A, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

`ifdef MDIO_NOPRE_EN
    run_frame("nopre1", 1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    run_frame("nopre1_rd", 1'b0, 5'd3, 5'd2, 16'h0, 1'b1, 16'hBEEF, 16'hBEEF, 1'b0, 1'b1, 1'b0);
    run_frame("nopre0", 1'b1, 5'd1, 5'd0, 16'h1140, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
